// File: rtl/array_mult_driver.sv
// Sequencer for the pipelined N-lane array multiplier: it assembles operand vectors
// from a word stream, runs the multiplier pipeline for LAT+1 cycles, then streams the lanes out.
module array_mult_driver #(
  parameter int N   = 4,
  parameter int LAT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [35:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [35:0]          out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 mult_en,
  output logic                 mult_rst,
  output logic [N-1:0][35:0]   mult_dataa,
  output logic [N-1:0][35:0]   mult_datab,
  input  logic [N-1:0][35:0]   mult_result
);

  localparam int KW = $clog2(2 * N);
  localparam int RW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic [KW-1:0]      k_reg, k_next;
  logic [RW-1:0]      r_reg, r_next;
  logic [JW-1:0]      j_reg, j_next;
  logic               busy_reg;
  logic [N-1:0][35:0] dataa_reg, datab_reg, result_reg;
  logic               load_beat, capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD;
      k_reg     <= '0;
      r_reg     <= '0;
      j_reg     <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      r_reg     <= r_next;
      j_reg     <= j_next;
      // Idle means back in LOAD with nothing partially loaded.
      busy_reg  <= !(state_next == LOAD && k_next == '0);
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    r_next     = r_reg;
    j_next     = j_reg;
    in_ready   = 1'b0;
    mult_en    = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    load_beat  = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      LOAD: begin
        in_ready  = 1'b1;
        load_beat = in_valid;
        if (in_valid) begin
          if (k_reg == KW'(2 * N - 1)) begin
            state_next = RUN;
            k_next     = '0;
            r_next     = '0;
          end else begin
            k_next = k_reg + 1'b1;
          end
        end
      end
      RUN: begin
        mult_en = 1'b1;
        if (r_reg == RW'(LAT)) begin
          capture    = 1'b1;
          state_next = DRAIN;
          r_next     = '0;
          j_next     = '0;
        end else begin
          r_next = r_reg + 1'b1;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (j_reg == JW'(N - 1));
        if (out_ready) begin
          if (j_reg == JW'(N - 1)) begin
            state_next = LOAD;
            j_next     = '0;
          end else begin
            j_next = j_reg + 1'b1;
          end
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // Operand and result lane registers; operands persist until overwritten by a later load.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) begin
        dataa_reg[gi]  <= '0;
        datab_reg[gi]  <= '0;
        result_reg[gi] <= '0;
      end else begin
        if (load_beat && k_reg == KW'(gi))
          dataa_reg[gi] <= in_data;
        if (load_beat && k_reg == KW'(N + gi))
          datab_reg[gi] <= in_data;
        if (capture)
          result_reg[gi] <= mult_result[gi];
      end
    end
  end

  assign mult_rst   = rst;
  assign mult_dataa = dataa_reg;
  assign mult_datab = datab_reg;
  assign busy       = busy_reg;
  assign out_data   = (state_reg == DRAIN) ? result_reg[j_reg] : 36'd0;

endmodule

// File: tb/tb_array_mult_driver.sv
// Bench for array_mult_driver: a LAT-stage enable-gated multiplier model,
// a table of operations, and directed sequences for backpressure, gaps and mid-operation reset.
module tb_array_mult_driver;
  localparam int N   = 4;
  localparam int LAT = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [35:0]        in_data;
  logic               out_valid;
  logic               out_ready;
  logic [35:0]        out_data;
  logic               out_last;
  logic               busy;
  logic               mult_en;
  logic               mult_rst;
  logic [N-1:0][35:0] mult_dataa, mult_datab, mult_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  array_mult_driver #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .mult_en(mult_en), .mult_rst(mult_rst),
    .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_result(mult_result)
  );

  // Multiplier model: LAT enabled stages, low 36 bits of each lane product.
  function automatic logic [35:0] lo36(input logic [35:0] a, input logic [35:0] b);
    logic [71:0] p;
    p = {36'd0, a} * {36'd0, b};
    return p[35:0];
  endfunction

  logic [N-1:0][35:0] pipe [LAT];
  always @(posedge clk) begin
    if (mult_rst) begin
      for (int s = 0; s < LAT; s++) pipe[s] <= '0;
    end else if (mult_en) begin
      for (int i = 0; i < N; i++) pipe[0][i] <= lo36(mult_dataa[i], mult_datab[i]);
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
  end
  assign mult_result = pipe[LAT-1];

  typedef struct {
    logic [N-1:0][35:0] a;
    logic [N-1:0][35:0] b;
    logic [N-1:0][35:0] exp;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [N-1:0][35:0] mk(input logic [35:0] l0, input logic [35:0] l1,
                                            input logic [35:0] l2, input logic [35:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    for (int c = 0; c < cycles; c++) begin
      chk("mult_rst_during_rst", {63'd0, mult_rst}, 64'd1);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("mult_rst_after_rst", {63'd0, mult_rst}, 64'd0);
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
    chk("out_valid_after_rst", {63'd0, out_valid}, 64'd0);
    chk("mult_en_after_rst", {63'd0, mult_en}, 64'd0);
    chk("busy_after_rst", {63'd0, busy}, 64'd0);
    chk("out_data_after_rst", {28'd0, out_data}, 64'd0);
  endtask

  // Presents the first nbeats operand words (a lanes then b lanes), optionally idling between beats.
  task automatic load_op(input logic [N-1:0][35:0] a, input logic [N-1:0][35:0] b,
                         input bit gap, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if (gap) begin
        in_valid = 1'b0;
        tick();
      end
      chk("in_ready_load", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_data  = (i < N) ? a[i] : b[i-N];
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Called in the cycle after the last operand beat; keeps in_valid high to prove it is ignored.
  task automatic wait_result();
    int n;
    int en_cnt;
    n = 1;
    en_cnt = 0;
    chk("mult_en_first_run_cycle", {63'd0, mult_en}, 64'd1);
    chk("in_ready_run", {63'd0, in_ready}, 64'd0);
    chk("busy_run", {63'd0, busy}, 64'd1);
    in_valid = 1'b1;
    in_data  = 36'hABCDE0123;
    while (!out_valid && n < 50) begin
      if (mult_en) en_cnt++;
      tick();
      n++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk("latency_to_out_valid", n, LAT + 2);
    chk("mult_en_cycles", en_cnt, LAT + 1);
  endtask

  // Drains nbeats results; pat bit c gives out_ready for drain cycle c (1 once exhausted).
  task automatic drain(input logic [N-1:0][35:0] exp, input logic [15:0] pat,
                       input int patlen, input int nbeats);
    int j;
    int c;
    j = 0;
    c = 0;
    while (j < nbeats && c < 40) begin
      out_ready = (c < patlen) ? pat[c] : 1'b1;
      chk("out_valid_drain", {63'd0, out_valid}, 64'd1);
      chk("in_ready_drain", {63'd0, in_ready}, 64'd0);
      chk("out_data_lane", {28'd0, out_data}, {28'd0, exp[j]});
      chk("out_last_lane", {63'd0, out_last}, {63'd0, (j == N - 1)});
      if (out_ready) $display("result beat lane=%0d data=0x%0h last=%0b", j, out_data, out_last);
      if (out_ready) j++;
      tick();
      c++;
    end
    chk("drain_beats_done", j, nbeats);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input bit gap, input logic [15:0] pat, input int patlen);
    load_op(v.a, v.b, gap, 2 * N);
    wait_result();
    drain(v.exp, pat, patlen, N);
    chk("out_valid_after_op", {63'd0, out_valid}, 64'd0);
    chk("in_ready_after_op", {63'd0, in_ready}, 64'd1);
    chk("busy_after_op", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    tbl[0].a = mk(1, 2, 3, 4);
    tbl[0].b = mk(5, 6, 7, 8);
    tbl[0].exp = mk(5, 12, 21, 32);
    tbl[1].a = mk(36'hFFFFFFFFF, 1, 0, 2);
    tbl[1].b = mk(1, 36'hFFFFFFFFF, 9, 3);
    tbl[1].exp = mk(36'hFFFFFFFFF, 36'hFFFFFFFFF, 0, 6);
    tbl[2].a = mk(10, 0, 3, 100);
    tbl[2].b = mk(10, 7, 3, 0);
    tbl[2].exp = mk(100, 0, 9, 0);
    tbl[3].a = mk(36'h800000000, 36'h123456789, 36'hFFFFFFFFF, 36'd65536);
    tbl[3].b = mk(2, 36'h10, 36'hFFFFFFFFF, 36'd65536);
    tbl[3].exp = mk(0, 36'h234567890, 1, 36'h100000000);
    tbl[4].a = mk(7, 11, 13, 17);
    tbl[4].b = mk(3, 5, 2, 4);
    tbl[4].exp = mk(21, 55, 26, 68);

    do_reset(2);

    // Table of operations, out_ready held high; consecutive entries run back to back.
    for (int i = 0; i < 5; i++) begin
      $display("table op %0d", i);
      run_op(tbl[i], 1'b0, 16'hFFFF, 0);
    end

    $display("backpressure op");
    run_op(tbl[0], 1'b0, 16'b1101001, 7);

    $display("input gap op");
    run_op(tbl[0], 1'b1, 16'hFFFF, 0);

    $display("reset after 5 operand beats");
    load_op(tbl[0].a, tbl[0].b, 1'b0, 5);
    chk("busy_mid_load", {63'd0, busy}, 64'd1);
    do_reset(1);
    run_op(tbl[1], 1'b0, 16'hFFFF, 0);

    $display("reset after 2 result beats");
    load_op(tbl[4].a, tbl[4].b, 1'b0, 2 * N);
    wait_result();
    drain(tbl[4].exp, 16'hFFFF, 0, 2);
    do_reset(1);
    run_op(tbl[1], 1'b0, 16'hFFFF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
